norm_stream: RTL and testbench

NORM_STREAM -- requirements
Module: norm_stream

---
 rtl/norm_pkg.sv | 25 ++
 rtl/norm_lane.sv | 80 ++++++++
 rtl/norm_stream.sv | 133 +++++++++++++
 tb/tb_norm_stream.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/norm_pkg.sv
// Shared types and constants for the norm_stream block-normalization datapath.
package norm_pkg;

  localparam int SAT_CNT_W = 16;

  typedef enum logic [1:0] {
    HALF_UP   = 2'b00,
    TRUNC     = 2'b01,
    HALF_EVEN = 2'b10
  } round_mode_e;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACTIVE = 1'b1
  } norm_state_e;

  function automatic int out_max(input int out_w);
    return (1 << (out_w - 1)) - 1;
  endfunction

  function automatic int out_min(input int out_w);
    return -(1 << (out_w - 1));
  endfunction

endpackage

// File: rtl/norm_lane.sv
// One lane of the normalizer: rounding add feeding the S1 register, then
// arithmetic shift and saturation registered in S2.
module norm_lane
  import norm_pkg::*;
#(
  parameter int IN_W    = 24,
  parameter int OUT_W   = 16,
  parameter int SHIFT_W = 5
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en_i,
  input  logic signed [IN_W-1:0]  x_i,
  input  logic [SHIFT_W-1:0]      shift_i,
  input  logic [1:0]              mode_i,
  input  logic [SHIFT_W-1:0]      s1_shift_i,
  output logic signed [OUT_W-1:0] data_o,
  output logic                    sat_o,
  output logic                    sat_next_o
);

  localparam int SUM_W = IN_W + 1;
  localparam logic signed [SUM_W-1:0] MAX_V = SUM_W'(out_max(OUT_W));
  localparam logic signed [SUM_W-1:0] MIN_V = SUM_W'(out_min(OUT_W));

  logic [SUM_W-1:0]        half;
  logic [SUM_W-1:0]        rnd;
  logic signed [SUM_W-1:0] sum_d;
  logic signed [SUM_W-1:0] sum_q;
  logic signed [SUM_W-1:0] shifted;
  logic signed [OUT_W-1:0] data_d;
  logic signed [OUT_W-1:0] data_q;
  logic                    sat_d;
  logic                    sat_q;

  // S1: one extra bit of headroom so x+R never overflows.
  always_comb begin
    half = '0;
    rnd  = '0;
    if (shift_i != '0) begin
      half = SUM_W'(1) << (shift_i - 1'b1);
      case (round_mode_e'(mode_i))
        TRUNC:     rnd = '0;
        HALF_EVEN: rnd = half - SUM_W'(1) + SUM_W'(x_i[shift_i]);
        default:   rnd = half;
      endcase
    end
    sum_d = $signed({x_i[IN_W-1], x_i}) + $signed(rnd);
  end

  always_comb begin
    shifted = sum_q >>> s1_shift_i;
    sat_d   = 1'b0;
    data_d  = shifted[OUT_W-1:0];
    if (shifted > MAX_V) begin
      sat_d  = 1'b1;
      data_d = MAX_V[OUT_W-1:0];
    end else if (shifted < MIN_V) begin
      sat_d  = 1'b1;
      data_d = MIN_V[OUT_W-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sum_q  <= '0;
      data_q <= '0;
      sat_q  <= 1'b0;
    end else if (en_i) begin
      sum_q  <= sum_d;
      data_q <= data_d;
      sat_q  <= sat_d;
    end
  end

  assign data_o     = data_q;
  assign sat_o      = sat_q;
  assign sat_next_o = sat_d;

endmodule

// File: rtl/norm_stream.sv
// Streaming block normalizer: per-block latched shift/rounding, per-lane
// saturation flags and a per-block clipped-sample count.
module norm_stream
  import norm_pkg::*;
#(
  parameter int IN_W    = 24,
  parameter int OUT_W   = 16,
  parameter int LANES   = 4,
  parameter int SHIFT_W = 5
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [SHIFT_W-1:0]       cfg_shift,
  input  logic [1:0]               cfg_mode,
  input  logic                     s_valid,
  output logic                     s_ready,
  input  logic [LANES*IN_W-1:0]    s_data,
  input  logic                     s_last,
  output logic                     m_valid,
  input  logic                     m_ready,
  output logic [LANES*OUT_W-1:0]   m_data,
  output logic [LANES-1:0]         m_sat,
  output logic                     m_last,
  output logic [SAT_CNT_W-1:0]     blk_sat_cnt,
  output logic                     busy
);

  // Handshake: a beat moves on a cycle where valid && ready. The whole
  // pipeline advances on en; an output beat stays frozen until m_ready.
  norm_state_e state_q, state_d;

  logic                 en;
  logic                 accept;
  logic                 first_beat;
  logic [SHIFT_W-1:0]   cfg_shift_q;
  logic [1:0]           cfg_mode_q;
  logic [SHIFT_W-1:0]   sel_shift;
  logic [SHIFT_W-1:0]   eff_shift;
  logic [1:0]           sel_mode;
  logic                 s1_valid_q;
  logic                 s1_last_q;
  logic                 s1_first_q;
  logic [SHIFT_W-1:0]   s1_shift_q;
  logic                 m_valid_q;
  logic                 m_last_q;
  logic [SAT_CNT_W-1:0] cnt_q;
  logic [SAT_CNT_W-1:0] cnt_d;
  logic [SAT_CNT_W:0]   pop;
  logic [SAT_CNT_W:0]   tot;
  logic [LANES-1:0]     sat_next;

  assign en         = !m_valid_q || m_ready;
  assign s_ready    = en || rst;
  assign accept     = s_valid && en;
  assign first_beat = (state_q == ST_IDLE);

  // The first beat of a block uses the live config; later beats the latched copy.
  assign sel_shift = first_beat ? cfg_shift : cfg_shift_q;
  assign sel_mode  = first_beat ? cfg_mode  : cfg_mode_q;

  always_comb begin
    eff_shift = sel_shift;
    if (32'(sel_shift) > 32'(IN_W - 1)) eff_shift = SHIFT_W'(IN_W - 1);
  end

  always_comb begin
    state_d = state_q;
    if (accept) state_d = s_last ? ST_IDLE : ST_ACTIVE;
  end

  // Count is aligned with S2 so the value shown with m_last includes that beat.
  always_comb begin
    pop = '0;
    for (int i = 0; i < LANES; i++) pop = pop + (SAT_CNT_W + 1)'(sat_next[i]);
    tot   = (s1_first_q ? '0 : {1'b0, cnt_q}) + pop;
    cnt_d = tot[SAT_CNT_W] ? '1 : tot[SAT_CNT_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cfg_shift_q <= '0;
      cfg_mode_q  <= 2'b00;
      s1_valid_q  <= 1'b0;
      s1_last_q   <= 1'b0;
      s1_first_q  <= 1'b0;
      s1_shift_q  <= '0;
      m_valid_q   <= 1'b0;
      m_last_q    <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q <= state_d;
      if (accept && first_beat) begin
        cfg_shift_q <= cfg_shift;
        cfg_mode_q  <= cfg_mode;
      end
      if (en) begin
        s1_valid_q <= accept;
        s1_last_q  <= s_last;
        s1_first_q <= first_beat;
        s1_shift_q <= eff_shift;
        m_valid_q  <= s1_valid_q;
        m_last_q   <= s1_last_q;
        if (s1_valid_q) cnt_q <= cnt_d;
      end
    end
  end

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    norm_lane #(
      .IN_W    (IN_W),
      .OUT_W   (OUT_W),
      .SHIFT_W (SHIFT_W)
    ) u_lane (
      .clk        (clk),
      .rst        (rst),
      .en_i       (en),
      .x_i        (s_data[g*IN_W +: IN_W]),
      .shift_i    (eff_shift),
      .mode_i     (sel_mode),
      .s1_shift_i (s1_shift_q),
      .data_o     (m_data[g*OUT_W +: OUT_W]),
      .sat_o      (m_sat[g]),
      .sat_next_o (sat_next[g])
    );
  end

  assign m_valid     = m_valid_q;
  assign m_last      = m_last_q;
  assign blk_sat_cnt = cnt_q;
  assign busy        = (state_q == ST_ACTIVE);

endmodule

// File: tb/tb_norm_stream.sv
// Self-checking bench for norm_stream: directed vectors, block counting,
// random backpressure, mid-block config change and mid-block reset.
module tb_norm_stream;
  import norm_pkg::*;

  localparam int IN_W    = 24;
  localparam int OUT_W   = 16;
  localparam int LANES   = 4;
  localparam int SHIFT_W = 5;
  localparam int DW      = LANES * IN_W;
  localparam int OW      = LANES * OUT_W;
  localparam int EW      = OW + LANES + 1 + SAT_CNT_W;
  localparam longint YMAX = (longint'(1) << (OUT_W - 1)) - 1;
  localparam longint YMIN = -(longint'(1) << (OUT_W - 1));

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic [SHIFT_W-1:0]   cfg_shift;
  logic [1:0]           cfg_mode;
  logic                 s_valid;
  logic                 s_ready;
  logic [DW-1:0]        s_data;
  logic                 s_last;
  logic                 m_valid;
  logic                 m_ready;
  logic [OW-1:0]        m_data;
  logic [LANES-1:0]     m_sat;
  logic                 m_last;
  logic [SAT_CNT_W-1:0] blk_sat_cnt;
  logic                 busy;

  logic [EW-1:0] exp_q[$];
  int checks = 0;
  int errors = 0;

  bit         m_in_blk = 1'b0;
  int         m_sh = 0;
  logic [1:0] m_md = 2'b00;
  int         m_cnt = 0;

  bit               bp_en = 1'b0;
  bit               held = 1'b0;
  logic [OW-1:0]    held_data;
  logic [LANES-1:0] held_sat;
  logic             held_last;
  logic [EW-1:0]    e;

  // clock / reset
  always #5 clk = ~clk;

  norm_stream #(
    .IN_W(IN_W), .OUT_W(OUT_W), .LANES(LANES), .SHIFT_W(SHIFT_W)
  ) dut (
    .clk(clk), .rst(rst), .cfg_shift(cfg_shift), .cfg_mode(cfg_mode),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_sat(m_sat),
    .m_last(m_last), .blk_sat_cnt(blk_sat_cnt), .busy(busy)
  );

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", tag, act, exp_v);
    end
  endtask

  function automatic logic [DW-1:0] pack4(input int a0, input int a1, input int a2, input int a3);
    return {24'(a3), 24'(a2), 24'(a1), 24'(a0)};
  endfunction

  function automatic logic [OW-1:0] packo(input int b0, input int b1, input int b2, input int b3);
    return {16'(b3), 16'(b2), 16'(b1), 16'(b0)};
  endfunction

  // Reference rounding: floor quotient plus explicit remainder comparison.
  function automatic longint round_ref(input longint x, input int s, input logic [1:0] md);
    longint p, q, rem, half;
    if (s == 0) return x;
    p    = longint'(1) << s;
    q    = x >>> s;
    rem  = x - q * p;
    half = p / 2;
    case (md)
      2'b01: ;
      2'b10: if (rem > half || (rem == half && q[0])) q++;
      default: if (rem >= half) q++;
    endcase
    return q;
  endfunction

  task automatic model_push(input logic [DW-1:0] d, input logic last, input int sh, input logic [1:0] md);
    logic [OW-1:0]    od;
    logic [LANES-1:0] sat;
    longint           x, y;
    int               s;
    if (!m_in_blk) begin
      m_sh  = sh;
      m_md  = md;
      m_cnt = 0;
    end
    s   = (m_sh > IN_W - 1) ? IN_W - 1 : m_sh;
    sat = '0;
    od  = '0;
    for (int i = 0; i < LANES; i++) begin
      x = longint'($signed(d[i*IN_W +: IN_W]));
      y = round_ref(x, s, m_md);
      if (y > YMAX) begin
        y = YMAX; sat[i] = 1'b1;
      end else if (y < YMIN) begin
        y = YMIN; sat[i] = 1'b1;
      end
      od[i*OUT_W +: OUT_W] = y[OUT_W-1:0];
      if (sat[i]) m_cnt++;
    end
    if (m_cnt > 65535) m_cnt = 65535;
    exp_q.push_back({m_cnt[15:0], last, sat, od});
    m_in_blk = !last;
  endtask

  // driver: called at posedge+1; returns at posedge+1 after the accept edge
  task automatic send_beat(input logic [DW-1:0] d, input logic last, input int sh, input logic [1:0] md);
    int n = 0;
    bit ok = 1'b0;
    s_valid = 1'b1; s_data = d; s_last = last;
    cfg_shift = SHIFT_W'(sh); cfg_mode = md;
    while (n < 200) begin
      @(negedge clk);
      if (s_ready) begin ok = 1'b1; break; end
      n++;
    end
    if (!ok) begin
      chk("accept_timeout", 64'd0, 64'd1);
      s_valid = 1'b0;
      return;
    end
    model_push(d, last, sh, md);
    @(posedge clk); #1;
    s_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("drain_empty", 64'(exp_q.size()), 64'd0);
    @(posedge clk); #1;
  endtask

  task automatic directed(input logic [DW-1:0] d, input int sh, input logic [1:0] md,
                          input logic [OW-1:0] ed, input logic [LANES-1:0] es, input string tag);
    send_beat(d, 1'b1, sh, md);
    @(negedge clk);
    chk({tag, "_lat1_valid"}, 64'(m_valid), 64'd0);
    @(negedge clk);
    chk({tag, "_lat2_valid"}, 64'(m_valid), 64'd1);
    chk({tag, "_data"}, 64'(m_data), 64'(ed));
    chk({tag, "_sat"}, 64'(m_sat), 64'(es));
    @(posedge clk); #1;
  endtask

  // scoreboard / monitor
  always @(negedge clk) begin
    if (rst) begin
      held = 1'b0;
    end else begin
      if (held) begin
        chk("hold_valid", 64'(m_valid), 64'd1);
        chk("hold_data", 64'(m_data), 64'(held_data));
        chk("hold_sat_last", 64'({m_sat, m_last}), 64'({held_sat, held_last}));
      end
      if (m_valid && m_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_beat", 64'd1, 64'd0);
        end else begin
          e = exp_q.pop_front();
          chk("beat_data", 64'(m_data), 64'(e[OW-1:0]));
          chk("beat_sat", 64'(m_sat), 64'(e[OW+LANES-1:OW]));
          chk("beat_last", 64'(m_last), 64'(e[OW+LANES]));
          if (e[OW+LANES]) chk("blk_sat_cnt", 64'(blk_sat_cnt), 64'(e[EW-1:OW+LANES+1]));
        end
      end
      held      = m_valid && !m_ready;
      held_data = m_data;
      held_sat  = m_sat;
      held_last = m_last;
    end
  end

  initial begin
    forever begin
      @(posedge clk); #1;
      if (bp_en) m_ready = 1'($urandom_range(0, 1));
    end
  end

  initial begin
    logic [DW-1:0] v32, v33, v34, vc, vr;
    v32 = pack4(8192, 8191, -8192, -8193);
    v33 = pack4(8192, 24576, -8192, 40960);
    v34 = pack4(8388607, 8388608, 524272, -524288);
    vc  = pack4(100000, -100000, 70000, 12345);
    cfg_shift = '0; cfg_mode = 2'b00; s_valid = 1'b0; s_data = '0; s_last = 1'b0;
    m_ready = 1'b0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_m_valid", 64'(m_valid), 64'd0);
    chk("rst_m_data", 64'(m_data), 64'd0);
    chk("rst_m_sat_last", 64'({m_sat, m_last}), 64'd0);
    chk("rst_blk_sat_cnt", 64'(blk_sat_cnt), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_s_ready", 64'(s_ready), 64'd1);
    @(posedge clk); #1;
    rst = 1'b0;
    m_ready = 1'b1;

    directed(v32, 14, 2'b00, packo(1, 0, 0, -1), 4'b0000, "half_up");
    directed(v33, 14, 2'b10, packo(0, 2, 0, 2), 4'b0000, "half_even");
    directed(v34, 4, 2'b00, packo(32767, -32768, 32767, -32768), 4'b0011, "saturate");

    // saturation count: 4 clipped-pair beats, then a clean block
    for (int i = 0; i < 4; i++) send_beat(v34, 1'(i == 3), 4, 2'b00);
    for (int i = 0; i < 2; i++) send_beat(v32, 1'(i == 1), 14, 2'b00);
    drain();

    // random beats under backpressure
    bp_en = 1'b1;
    for (int i = 0; i < 16; i++) begin
      vr = {24'($urandom()), 24'($urandom()), 24'($urandom()), 24'($urandom())};
      send_beat(vr, 1'(i == 15 || $urandom_range(0, 3) == 0),
                int'($urandom_range(0, 31)), 2'($urandom_range(0, 3)));
    end
    bp_en = 1'b0;
    m_ready = 1'b1;
    drain();

    // config change mid-block must not take effect
    send_beat(vc, 1'b0, 14, 2'b00);
    chk("busy_mid_block", 64'(busy), 64'd1);
    send_beat(vc, 1'b0, 2, 2'b01);
    send_beat(vc, 1'b0, 2, 2'b01);
    send_beat(vc, 1'b1, 2, 2'b01);
    chk("busy_after_last", 64'(busy), 64'd0);
    drain();

    // reset mid-block, with a beat presented during reset
    send_beat(vc, 1'b0, 14, 2'b00);
    send_beat(vc, 1'b0, 14, 2'b00);
    rst = 1'b1;
    exp_q.delete();
    m_in_blk = 1'b0;
    s_valid = 1'b1; s_data = v34; s_last = 1'b0;
    @(posedge clk); #1;
    s_valid = 1'b0;
    chk("rst_mid_m_valid", 64'(m_valid), 64'd0);
    chk("rst_mid_busy", 64'(busy), 64'd0);
    rst = 1'b0;
    directed(v32, 14, 2'b00, packo(1, 0, 0, -1), 4'b0000, "post_rst");
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
